// File: rtl/xf_matrix_mem_arbiter.sv
// Round-robin arbiter sharing the XF matrix memory read port between NREQ fetch units.
// Each grant issues a 1-4 row burst; read data is broadcast, read-valid goes to the owner only.
module xf_matrix_mem_arbiter #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 128,
    parameter int IDW   = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] reqAddr,
    input  logic [2*NREQ-1:0] reqRows,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rdValid,
    output logic [WIDTH-1:0]  rdData,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [IDW-1:0]    owner,
    output logic [6:0]        memAddr,
    output logic              memEnable,
    input  logic [WIDTH-1:0]  memData,
    input  logic              memValid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [6:0]      base_addr_q, base_addr_d;
    logic [1:0]      last_row_q, last_row_d;
    logic [1:0]      issue_cnt_q, issue_cnt_d;
    logic [2:0]      ret_cnt_q, ret_cnt_d;
    logic [NREQ-1:0] done_q, done_d;

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [IDW:0]    cand;
    logic            active;
    logic            last_ret;

    assign active   = (state_q != IDLE);
    assign last_ret = active && memValid && (ret_cnt_q == {1'b0, last_row_q});

    // First pending requester at or above rrPtr, wrapping modulo NREQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!win_found && req[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            base_addr_q <= '0;
            last_row_q  <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            base_addr_q <= base_addr_d;
            last_row_q  <= last_row_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        base_addr_d = base_addr_q;
        last_row_d  = last_row_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        done_d      = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d     = win_idx;
                    base_addr_d = reqAddr[7*win_idx +: 7];
                    last_row_d  = reqRows[2*win_idx +: 2];
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    rr_ptr_d    = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                    state_d     = BURST;
                end
            end
            BURST: begin
                issue_cnt_d = issue_cnt_q + 2'd1;
                if (issue_cnt_q == last_row_q)
                    state_d = DRAIN;
            end
            default: ;
        endcase
        if (active && memValid)
            ret_cnt_d = ret_cnt_q + 3'd1;
        // Final return closes the burst; done is shown in the following (IDLE) cycle
        if (last_ret) begin
            state_d         = IDLE;
            done_d[owner_q] = 1'b1;
        end
    end

    always_comb begin
        gnt       = '0;
        rdValid   = '0;
        memEnable = 1'b0;
        memAddr   = '0;
        busy      = active;
        if (state_q == BURST) begin
            memEnable = 1'b1;
            memAddr   = base_addr_q + {5'b0, issue_cnt_q};
            if (issue_cnt_q == 2'd0)
                gnt[owner_q] = 1'b1;
        end
        if (active)
            rdValid[owner_q] = memValid;
    end

    assign rdData = memData;
    assign done   = done_q;
    assign owner  = owner_q;

endmodule
